// File: rtl/fp_cvt_sched_pkg.sv
// Shared types for the FP convert scheduler: converter format codes,
// tag-pipe stage layout and scheduler FSM states.
package fpCvtPkg;

    // Source format codes driven to the converter.
    typedef enum logic [1:0] {
        FMT_S   = 2'b00,
        FMT_D   = 2'b01,
        FMT_Q   = 2'b10,
        FMT_RSV = 2'b11
    } cvt_fmt_e;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Stage fields are sized for the largest supported configuration
    // (NREQ <= 8, TAGW <= 16); narrower instances use the low bits.
    localparam int ID_WMAX  = 3;
    localparam int TAG_WMAX = 16;

    typedef struct packed {
        logic                v;
        logic [ID_WMAX-1:0]  id;
        logic [TAG_WMAX-1:0] tag;
    } pipe_stage_t;

endpackage

// File: rtl/fp_cvt_sched_arb.sv
// Round-robin arbiter with a one-hot grant. The grant depends only on the
// request vector and the pointer, so it can feed a ready/valid handshake
// without a combinational loop.
module fp_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_vld_o
);

    logic [IW-1:0] rr_q, rr_d;
    int            idx;

    // Scan requesters starting at the pointer; first one found wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        idx       = 0;
        for (int off = 0; off < N; off++) begin
            idx = int'(rr_q) + off;
            if (idx >= N) idx = idx - N;
            if (!gnt_vld_o && req_i[idx]) begin
                gnt_vld_o      = 1'b1;
                gnt_o[idx]     = 1'b1;
                gnt_idx_o      = IW'(idx);
            end
        end
    end

    // Pointer moves just past the winner; holds when nobody is granted.
    always_comb begin
        rr_d = rr_q;
        if (gnt_vld_o)
            rr_d = (gnt_idx_o == IW'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_q <= '0;
        else     rr_q <= rr_d;
    end

endmodule

// File: rtl/fp_cvt_sched.sv
// Shares one pipelined precision converter among NREQ requesters. Issues at
// most one op per cycle, tracks in-flight ops in a LAT-deep tag pipe and
// parks each result in a per-requester holding register until acked.
module fp_cvt_sched
    import fpCvtPkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    parameter int TAGW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [2*NREQ-1:0]    req_fmt,
    input  logic [128*NREQ-1:0]  req_data,
    input  logic [TAGW*NREQ-1:0] req_tag,
    input  logic                 flush,
    output logic                 cvt_ld,
    output logic [1:0]           cvt_fmt,
    output logic [127:0]         cvt_i,
    input  logic [127:0]         cvt_o,
    output logic [NREQ-1:0]      resp_valid,
    output logic [128*NREQ-1:0]  resp_data,
    output logic [TAGW*NREQ-1:0] resp_tag,
    input  logic [NREQ-1:0]      resp_ack,
    output logic                 busy
);

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0][1:0]      fmt_v;
    logic [NREQ-1:0][127:0]    data_v;
    logic [NREQ-1:0][TAGW-1:0] tag_v;

    state_e                    state_q, state_d;
    logic [NREQ-1:0]           outst_q, outst_d;
    logic [NREQ-1:0]           rvld_q, rvld_d;
    logic [NREQ-1:0][127:0]    rdata_q;
    logic [NREQ-1:0][TAGW-1:0] rtag_q;
    pipe_stage_t [LAT-1:0]     pipe_q, pipe_d;

    logic [NREQ-1:0]           elig, gnt;
    logic [IDW-1:0]            gnt_idx, cap_id;
    logic                      gnt_vld, cap, pipe_busy, flush_entry;
    logic [TAGW-1:0]           tag_sel, cap_tag;
    logic                      unused_pipe_bits;

    assign fmt_v  = req_fmt;
    assign data_v = req_data;
    assign tag_v  = req_tag;

    // Requesters with a free slot and a legal format may compete; reset
    // also masks them so every output reads zero while rst is high.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++)
            elig[i] = req_valid[i] & ~outst_q[i] & (fmt_v[i] != FMT_RSV)
                      & (state_q == RUN) & ~rst;
    end

    fp_rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (elig),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign req_ready = gnt;
    assign cvt_ld    = gnt_vld;

    // Steer the winner's operand to the converter; all zero when idle.
    always_comb begin
        cvt_fmt = '0;
        cvt_i   = '0;
        tag_sel = '0;
        if (gnt_vld) begin
            cvt_fmt = fmt_v[gnt_idx];
            cvt_i   = data_v[gnt_idx];
            tag_sel = tag_v[gnt_idx];
        end
    end

    // Tag pipe advances every cycle, in step with the converter.
    always_comb begin
        pipe_d                   = '0;
        pipe_d[0].v              = gnt_vld;
        pipe_d[0].id[IDW-1:0]    = gnt_idx;
        pipe_d[0].tag[TAGW-1:0]  = tag_sel;
        for (int k = 1; k < LAT; k++)
            pipe_d[k] = pipe_q[k-1];
    end

    assign flush_entry      = (state_q == RUN) & flush;
    assign cap              = pipe_q[LAT-1].v & (state_q == RUN) & ~flush;
    assign cap_id           = pipe_q[LAT-1].id[IDW-1:0];
    assign cap_tag          = pipe_q[LAT-1].tag[TAGW-1:0];
    assign unused_pipe_bits = ^pipe_q[LAT-1];

    // Any live op in the pipe keeps DRAIN from exiting.
    always_comb begin
        pipe_busy = 1'b0;
        for (int k = 0; k < LAT; k++)
            pipe_busy = pipe_busy | pipe_q[k].v;
    end

    // Slot bookkeeping: ack frees a slot, grant claims it, capture marks the
    // result held; a flush wipes everything on the way into DRAIN.
    always_comb begin
        outst_d = outst_q;
        rvld_d  = rvld_q;
        for (int i = 0; i < NREQ; i++) begin
            if (resp_ack[i] & rvld_q[i]) begin
                outst_d[i] = 1'b0;
                rvld_d[i]  = 1'b0;
            end
        end
        outst_d = outst_d | gnt;
        if (cap) rvld_d[cap_id] = 1'b1;
        if (flush_entry) begin
            outst_d = '0;
            rvld_d  = '0;
        end
    end

    // DRAIN holds off new grants until the pipe is empty and flush is gone.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush) state_d = DRAIN;
            DRAIN:   if (!pipe_busy && !flush) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            outst_q <= '0;
            rvld_q  <= '0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            outst_q <= outst_d;
            rvld_q  <= rvld_d;
            pipe_q  <= pipe_d;
        end
    end

    // Result holding registers, written only on capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            rtag_q  <= '0;
        end else if (cap) begin
            rdata_q[cap_id] <= cvt_o;
            rtag_q[cap_id]  <= cap_tag;
        end
    end

    assign resp_valid = rvld_q;
    assign resp_data  = rdata_q;
    assign resp_tag   = rtag_q;
    assign busy       = (state_q == DRAIN) | pipe_busy | (|outst_q);

endmodule

// File: tb/tb_fp_cvt_sched.sv
// Directed bench for fp_cvt_sched with a behavioural LAT-deep converter.
module tb_fp_cvt_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int TAGW = 4;

    localparam logic [127:0] Q_ONE = 128'h3FFF0000_00000000_00000000_00000000;
    localparam logic [127:0] Q_INF = 128'h7FFF0000_00000000_00000000_00000000;
    localparam logic [127:0] S_ONE = 128'h3F800000;
    localparam logic [127:0] S_INF = 128'h7F800000;
    localparam logic [127:0] D_ONE = 128'h3FF00000_00000000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [2*NREQ-1:0]    req_fmt;
    logic [128*NREQ-1:0]  req_data;
    logic [TAGW*NREQ-1:0] req_tag;
    logic                 flush;
    logic                 cvt_ld;
    logic [1:0]           cvt_fmt;
    logic [127:0]         cvt_i;
    logic [127:0]         cvt_o;
    logic [NREQ-1:0]      resp_valid;
    logic [128*NREQ-1:0]  resp_data;
    logic [TAGW*NREQ-1:0] resp_tag;
    logic [NREQ-1:0]      resp_ack;
    logic                 busy;

    int n_tot = 0;
    int n_bad = 0;

    fp_cvt_sched #(.NREQ(NREQ), .LAT(LAT), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt),
        .req_data(req_data), .req_tag(req_tag), .flush(flush),
        .cvt_ld(cvt_ld), .cvt_fmt(cvt_fmt), .cvt_i(cvt_i), .cvt_o(cvt_o),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag),
        .resp_ack(resp_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference single/double -> quad widening for normal, zero and inf/nan.
    function automatic logic [127:0] cvt_model(input logic [1:0] f, input logic [127:0] x);
        logic [127:0] r;
        r = x;
        if (f == 2'b00) begin
            if (x[30:23] == 8'h00)      r = {x[31], 127'b0};
            else if (x[30:23] == 8'hFF) r = {x[31], 15'h7FFF, x[22:0], 89'b0};
            else                        r = {x[31], 15'(x[30:23]) + 15'd16256, x[22:0], 89'b0};
        end else if (f == 2'b01) begin
            if (x[62:52] == 11'h000)      r = {x[63], 127'b0};
            else if (x[62:52] == 11'h7FF) r = {x[63], 15'h7FFF, x[51:0], 60'b0};
            else                          r = {x[63], 15'(x[62:52]) + 15'd15360, x[51:0], 60'b0};
        end
        return r;
    endfunction

    logic [127:0] cp [LAT];
    always @(posedge clk) begin
        cp[0] <= cvt_model(cvt_fmt, cvt_i);
        for (int k = 1; k < LAT; k++) cp[k] <= cp[k-1];
    end
    assign cvt_o = cp[LAT-1];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] f, input logic [127:0] d, input logic [3:0] t);
        req_fmt[2*i +: 2]    = f;
        req_data[128*i +: 128] = d;
        req_tag[TAGW*i +: TAGW] = t;
        req_valid[i]         = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0; req_fmt = '0; req_data = '0; req_tag = '0;
        resp_ack = '0; flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", n_tot, n_bad);
        $fatal(1);
    end

    initial begin
        // Reset state, with a pending request that must stay masked.
        do_reset();
        rst = 1'b1;
        set_req(0, 2'b00, S_ONE, 4'd5);
        #1;
        chk("rst_ready", 128'(req_ready), 128'h0);
        chk("rst_ld", 128'(cvt_ld), 128'h0);
        chk("rst_cvt_i", cvt_i, 128'h0);
        chk("rst_rvld", 128'(resp_valid), 128'h0);
        chk("rst_busy", 128'(busy), 128'h0);

        // Single request: issue same cycle, result after LAT+1 clocks.
        rst = 1'b0;
        #1;
        chk("s1_ready", 128'(req_ready), 128'h1);
        chk("s1_ld", 128'(cvt_ld), 128'h1);
        chk("s1_cvt_i", cvt_i, S_ONE);
        chk("s1_fmt", 128'(cvt_fmt), 128'h0);
        tick();
        req_valid = '0;
        #1;
        chk("s1_busy", 128'(busy), 128'h1);
        tick();
        chk("s1_rvld_early", 128'(resp_valid), 128'h0);
        tick();
        chk("s1_rvld", 128'(resp_valid), 128'h1);
        chk("s1_data", resp_data[127:0], Q_ONE);
        chk("s1_tag", 128'(resp_tag[3:0]), 128'h5);
        resp_ack = 4'b0001;
        tick();
        resp_ack = '0;
        #1;
        chk("s1_rvld_ack", 128'(resp_valid), 128'h0);
        chk("s1_busy_idle", 128'(busy), 128'h0);

        // Four doubles at once: grants 0..3 back to back, pointer wraps.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 2'b01, D_ONE, 4'(i + 1));
        for (int k = 0; k < NREQ; k++) begin
            #1;
            chk($sformatf("rr_gnt%0d", k), 128'(req_ready), 128'(1 << k));
            tick();
        end
        #1;
        chk("rr_none", 128'(req_ready), 128'h0);
        tick();
        tick();
        chk("rr_rvld", 128'(resp_valid), 128'hF);
        for (int i = 0; i < NREQ; i++) begin
            chk($sformatf("rr_data%0d", i), resp_data[128*i +: 128], Q_ONE);
            chk($sformatf("rr_tag%0d", i), 128'(resp_tag[TAGW*i +: TAGW]), 128'(i + 1));
        end
        req_valid = '0;
        resp_ack  = 4'hF;
        tick();
        resp_ack = '0;
        #1;
        chk("rr_acked", 128'(resp_valid), 128'h0);
        set_req(0, 2'b00, S_ONE, 4'd0);
        set_req(3, 2'b00, S_ONE, 4'd0);
        #1;
        chk("rr_wrap", 128'(req_ready), 128'h1);

        // Infinity held without ack blocks re-issue until one cycle after ack.
        do_reset();
        set_req(2, 2'b00, S_INF, 4'd7);
        #1;
        chk("inf_gnt", 128'(req_ready), 128'h4);
        tick();
        chk("inf_blk1", 128'(req_ready), 128'h0);
        tick();
        chk("inf_blk2", 128'(req_ready), 128'h0);
        tick();
        chk("inf_rvld", 128'(resp_valid), 128'h4);
        chk("inf_data", resp_data[256 +: 128], Q_INF);
        chk("inf_tag", 128'(resp_tag[8 +: 4]), 128'h7);
        tick();
        chk("inf_hold", 128'(resp_valid), 128'h4);
        chk("inf_blk4", 128'(req_ready), 128'h0);
        tick();
        resp_ack = 4'b0100;
        #1;
        chk("inf_ack_cycle", 128'(req_ready), 128'h0);
        tick();
        resp_ack = '0;
        #1;
        chk("inf_regnt", 128'(req_ready), 128'h4);
        chk("inf_rvld_clr", 128'(resp_valid), 128'h0);

        // Flush with two ops in flight: no captures, DRAIN for LAT cycles.
        do_reset();
        set_req(0, 2'b00, S_ONE, 4'd1);
        set_req(1, 2'b00, S_ONE, 4'd2);
        tick();
        tick();
        req_valid = '0;
        flush = 1'b1;
        #1;
        chk("fl_busy0", 128'(busy), 128'h1);
        tick();
        flush = 1'b0;
        set_req(3, 2'b00, S_ONE, 4'd3);
        #1;
        chk("fl_rvld1", 128'(resp_valid), 128'h0);
        chk("fl_busy1", 128'(busy), 128'h1);
        chk("fl_nogrant1", 128'(req_ready), 128'h0);
        tick();
        chk("fl_rvld2", 128'(resp_valid), 128'h0);
        chk("fl_busy2", 128'(busy), 128'h1);
        chk("fl_nogrant2", 128'(req_ready), 128'h0);
        tick();
        req_valid = '0;
        set_req(1, 2'b01, D_ONE, 4'd9);
        #1;
        chk("fl_rvld3", 128'(resp_valid), 128'h0);
        chk("fl_busy3", 128'(busy), 128'h0);
        chk("fl_regnt", 128'(req_ready), 128'h2);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("fl_post_rvld", 128'(resp_valid), 128'h2);
        chk("fl_post_data", resp_data[128 +: 128], Q_ONE);
        chk("fl_post_tag", 128'(resp_tag[4 +: 4]), 128'h9);

        // Reserved format never wins; other requesters keep going.
        do_reset();
        set_req(1, 2'b11, S_ONE, 4'd4);
        set_req(3, 2'b00, S_ONE, 4'd6);
        #1;
        chk("rsv_gnt3", 128'(req_ready), 128'h8);
        tick();
        chk("rsv_blk1", 128'(req_ready), 128'h0);
        tick();
        chk("rsv_blk2", 128'(req_ready), 128'h0);
        tick();
        chk("rsv_rvld", 128'(resp_valid), 128'h8);
        resp_ack     = 4'b1000;
        req_valid[3] = 1'b0;
        #1;
        chk("rsv_blk3", 128'(req_ready), 128'h0);
        tick();
        resp_ack = '0;
        #1;
        chk("rsv_blk4", 128'(req_ready), 128'h0);
        chk("rsv_busy", 128'(busy), 128'h0);

        // Async reset mid-pipe: outputs drop at once, nothing stale later.
        do_reset();
        set_req(0, 2'b00, S_ONE, 4'd3);
        tick();
        req_valid = '0;
        tick();
        chk("ar_busy_pre", 128'(busy), 128'h1);
        #2;
        rst = 1'b1;
        set_req(2, 2'b00, S_ONE, 4'd1);
        #1;
        chk("ar_ready", 128'(req_ready), 128'h0);
        chk("ar_ld", 128'(cvt_ld), 128'h0);
        chk("ar_busy", 128'(busy), 128'h0);
        chk("ar_rvld", 128'(resp_valid), 128'h0);
        #2;
        req_valid = '0;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("ar_stale%0d", k), 128'(resp_valid), 128'h0);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_cvt_sched.md
Name: fp_cvt_sched

Overview:
- Round-robin scheduler that shares one fully pipelined precision converter among NREQ requesters. The converter is external, handles single→quad and double→quad, and has fixed latency LAT.
- Grants at most one request per cycle and drives the converter input.
- Tracks in-flight operations in a LAT-deep tag pipe and returns each result to its originating requester through a one-entry result holding register.
- Sits between the issue logic of several FP units and the shared quad-precision convert datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 2, converter latency in clocks from cvt_ld to cvt_o valid (1..8).
- TAGW, 4, width of the requester-supplied tag carried with each operation.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_ready  out  NREQ  grant. A transfer occurs when req_valid[i] & req_ready[i].
- req_fmt  in  2*NREQ  per-requester source format: 00 single, 01 double, 10 quad passthrough, 11 reserved.
- req_data  in  128*NREQ  operand, right-aligned.
- req_tag  in  TAGW*NREQ  opaque tag.
- flush  in  1  abandon all in-flight and unacknowledged results.
- cvt_ld  out  1  converter input valid.
- cvt_fmt  out  2  format to the converter.
- cvt_i  out  128  operand to the converter.
- cvt_o  in  128  converter result, valid exactly LAT cycles after cvt_ld.
- resp_valid  out  NREQ  result held for requester i.
- resp_data  out  128*NREQ  quad result.
- resp_tag  out  TAGW*NREQ  tag returned with the result.
- resp_ack  in  NREQ  consumes resp_valid[i].
- busy  out  1  any operation in flight or any result held.

Behaviour:
- Reset (async, rst=1) clears:
  - all outputs to 0;
  - the rr pointer to 0;
  - the tag pipe;
  - the outstanding[] bits;
  - the state to RUN.
- Eligibility: elig[i] = req_valid[i] & ~outstanding[i] & (req_fmt[i] != 11) & state==RUN.
  - Reserved format 11 is never granted; the requester stays pending.
- Arbitration:
  - Combinational round-robin over elig, starting at rr.
  - req_ready is one-hot or zero, and depends on elig only, not on req_ready.
  - On a grant to i: rr <= (i+1) mod NREQ. With no grant, rr holds.
- Issue, same cycle as the grant: cvt_ld=1, cvt_fmt=req_fmt[i], cvt_i=req_data[i].
  - These are combinational from the arbiter. cvt_ld=0 and cvt_fmt/cvt_i=0 when there is no grant.
- outstanding[i] is set on grant and cleared on the cycle resp_ack[i] & resp_valid[i].
  - Each requester has at most one operation in flight or held, so result capture never collides.
- Tag pipe: LAT stages of {v, id[$clog2(NREQ)-1:0], tag}.
  - Stage 0 is loaded on issue.
  - When stage LAT-1 has v=1, the result register is written: resp_data[id] <= cvt_o, resp_tag[id] <= tag, resp_valid[id] <= 1.
- resp_valid[i] is cleared on resp_ack[i]. resp_ack without resp_valid is ignored.
- A grant to i is not allowed in the same cycle as its ack. outstanding is updated registered, so re-issue occurs at the earliest one cycle after the ack.
- Total latency from grant to resp_valid: LAT+1 clocks (capture is registered).
- FSM states:
  - RUN: normal operation.
  - DRAIN: entered on flush=1 in RUN. No grants. Pipe contents are shifted but not captured. On entry, all resp_valid and outstanding bits are cleared. Returns to RUN when the pipe has no v bits and flush=0.
  - flush asserted while in DRAIN extends DRAIN.
- busy = (state==DRAIN) | any pipe v | any outstanding.
- Reset mid-operation discards everything. No result from before the reset may appear afterwards.

Decomposition:
- Shared package fpCvtPkg holds:
  - enum of the cvt_fmt encodings (FMT_S, FMT_D, FMT_Q, FMT_RSV);
  - the tag-pipe stage struct;
  - the FSM state enum (RUN, DRAIN).
- One natural sub-module, fp_rr_arbiter, containing the round-robin pointer and one-hot grant. It is reusable for the other shared FP units.
- The converter itself is outside this block.

Test Plan:
- Single request: req0 single 0x3F800000 → cvt_ld the same cycle; resp_valid[0] at LAT+1=3 clocks with resp_data=0x3FFF0000_00000000_00000000_00000000 and the tag echoed.
- All four requesters valid in the same cycle with doubles 0x3FF0000000000000 and tags 1..4 → grants in order 0,1,2,3 on consecutive cycles; each resp_data=0x3FFF0000_...0; the rr pointer wraps to 0.
- Infinity with outstanding block: req2 single 0x7F800000 held with no ack → the result is 0x7FFF0000_...0. req2 stays ungranted while outstanding, and is granted one cycle after resp_ack[2].
- Flush with two operations in flight → DRAIN for LAT cycles with no captures; resp_valid=0; busy falls after the pipe empties; the next request completes normally.
- Reserved format: req1 fmt=11 → never granted, while other requesters proceed.
- Async reset: assert rst mid-pipe, between clock edges → outputs go to 0 immediately; no stale resp_valid appears after release.
